// File: rtl/piece_spawner_pkg.sv
// rtl/piece_spawner_pkg.sv - piece types, FSM states, LFSR taps and spawn shape lookup
package tetris_pkg;

    typedef enum logic [2:0] {
        LINE      = 3'd0,
        SMASHBOY  = 3'd1,
        L         = 3'd2,
        REVERSE_L = 3'd3,
        S         = 3'd4,
        Z         = 3'd5,
        T         = 3'd6
    } block_t;

    typedef enum logic [1:0] {
        INIT_DRAW = 2'd0,
        IDLE      = 2'd1,
        EMIT      = 2'd2,
        DRAW      = 2'd3
    } spawn_state_t;

    localparam int NUM_PIECES = 7;
    // Fibonacci feedback from bits 7,5,4,3 for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int MASK_ROWS = 4;
    localparam int MAX_COLS  = 64;

    typedef logic [MASK_ROWS-1:0][MAX_COLS-1:0] shape_rows_t;

    // Every piece lives in the top four rows; callers slice the columns to their board width.
    function automatic shape_rows_t shape_mask(block_t piece, logic [5:0] c);
        shape_rows_t m;
        m = '0;
        case (piece)
            LINE:      begin m[0][c] = 1'b1; m[1][c] = 1'b1; m[2][c] = 1'b1; m[3][c] = 1'b1; end
            SMASHBOY:  begin m[0][c] = 1'b1; m[0][c+6'd1] = 1'b1; m[1][c] = 1'b1; m[1][c+6'd1] = 1'b1; end
            L:         begin m[0][c] = 1'b1; m[1][c] = 1'b1; m[2][c] = 1'b1; m[2][c+6'd1] = 1'b1; end
            REVERSE_L: begin m[0][c+6'd1] = 1'b1; m[1][c+6'd1] = 1'b1; m[2][c+6'd1] = 1'b1; m[2][c] = 1'b1; end
            S:         begin m[0][c+6'd2] = 1'b1; m[0][c+6'd1] = 1'b1; m[1][c+6'd1] = 1'b1; m[1][c] = 1'b1; end
            Z:         begin m[0][c] = 1'b1; m[0][c+6'd1] = 1'b1; m[1][c+6'd1] = 1'b1; m[1][c+6'd2] = 1'b1; end
            T:         begin m[0][c] = 1'b1; m[1][c-6'd1] = 1'b1; m[1][c] = 1'b1; m[1][c+6'd1] = 1'b1; end
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/piece_spawner_if.sv
// rtl/piece_spawner_if.sv - spawn request/response bundle between game control and spawner
interface piece_spawner_if #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 22
);
    logic                           spawn_req;
    logic [GRID_H-1:0][GRID_W-1:0]  board_in;
    logic                           ready;
    logic                           spawn_valid;
    logic [GRID_H-1:0][GRID_W-1:0]  spawn_mask;
    logic [2:0]                     piece_id;
    logic [2:0]                     next_piece;
    logic                           collision;
    logic                           game_over;

    modport master (
        output spawn_req, board_in,
        input  ready, spawn_valid, spawn_mask, piece_id, next_piece, collision, game_over
    );

    modport slave (
        input  spawn_req, board_in,
        output ready, spawn_valid, spawn_mask, piece_id, next_piece, collision, game_over
    );
endinterface

// File: rtl/tetromino_bag.sv
// rtl/tetromino_bag.sv - free-running LFSR feeding a 7-bag draw with bounded retries
module tetromino_bag
    import tetris_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       draw_start,
    output logic       draw_done,
    output logic [2:0] pick
);

    logic [7:0] lfsr;
    logic [6:0] bag_used;
    logic [2:0] retry;
    logic [2:0] cand;
    logic       cand_ok;
    logic [2:0] lowest;
    logic [6:0] bag_set;

    assign cand = lfsr[2:0];
    // Id 7 is treated as permanently used so it can never be accepted.
    assign cand_ok = ~({1'b1, bag_used} >> cand) & 1'b1 ? 1'b1 : 1'b0;

    always_comb begin
        lowest = 3'd0;
        casez (bag_used)
            7'b??????0: lowest = 3'd0;
            7'b?????01: lowest = 3'd1;
            7'b????011: lowest = 3'd2;
            7'b???0111: lowest = 3'd3;
            7'b??01111: lowest = 3'd4;
            7'b?011111: lowest = 3'd5;
            7'b0111111: lowest = 3'd6;
            default:    lowest = 3'd0;
        endcase
    end

    always_comb begin
        draw_done = 1'b0;
        pick      = cand;
        if (draw_start) begin
            if (retry == 3'd7) begin
                draw_done = 1'b1;
                pick      = lowest;
            end else if (cand_ok) begin
                draw_done = 1'b1;
            end
        end
    end

    assign bag_set = bag_used | (7'd1 << pick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= LFSR_SEED;
            bag_used <= '0;
            retry    <= '0;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            if (draw_done) begin
                retry    <= '0;
                bag_used <= (bag_set == 7'h7F) ? 7'h00 : bag_set;
            end else if (draw_start) begin
                retry <= retry + 3'd1;
            end
        end
    end

endmodule

// File: rtl/piece_spawner.sv
// rtl/piece_spawner.sv - spawn FSM: preview refill, mask build, collision and game over
module piece_spawner
    import tetris_pkg::*;
#(
    parameter int         GRID_W    = 10,
    parameter int         GRID_H    = 22,
    parameter int         SPAWN_COL = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    piece_spawner_if.slave  bus
);

    localparam logic [5:0] ANCHOR = 6'(SPAWN_COL);

    spawn_state_t                  state, state_nx;
    block_t                        next_q;
    logic [2:0]                    piece_q;
    logic [GRID_H-1:0][GRID_W-1:0] mask_q;
    logic                          coll_q;
    logic                          go_q;
    logic                          draw_start;
    logic                          draw_done;
    logic [2:0]                    pick;
    logic                          accept;
    shape_rows_t                   rows;
    logic [GRID_H-1:0][GRID_W-1:0] shape;
    logic                          collision;

    tetromino_bag #(.LFSR_SEED(LFSR_SEED)) u_bag (
        .clk        (clk),
        .rst        (rst),
        .draw_start (draw_start),
        .draw_done  (draw_done),
        .pick       (pick)
    );

    assign rows = shape_mask(next_q, ANCHOR);

    for (genvar r = 0; r < GRID_H; r++) begin : g_rows
        if (r < MASK_ROWS) begin : g_shape
            assign shape[r] = rows[r][GRID_W-1:0];
        end else begin : g_blank
            assign shape[r] = '0;
        end
    end

    assign collision = |(shape & bus.board_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT_DRAW;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        draw_start = 1'b0;
        accept     = 1'b0;
        case (state)
            INIT_DRAW, DRAW: begin
                draw_start = 1'b1;
                if (draw_done) state_nx = IDLE;
            end
            IDLE: begin
                if (bus.spawn_req && !go_q) begin
                    accept   = 1'b1;
                    state_nx = EMIT;
                end
            end
            EMIT:    state_nx = DRAW;
            default: state_nx = INIT_DRAW;
        endcase
    end

    // Spawn results are captured at the accept edge so they are valid throughout EMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_q  <= LINE;
            piece_q <= '0;
            mask_q  <= '0;
            coll_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            if (draw_done) next_q <= block_t'(pick);
            if (accept) begin
                piece_q <= next_q;
                mask_q  <= shape;
                coll_q  <= collision;
                if (collision) go_q <= 1'b1;
            end
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.spawn_valid = (state == EMIT);
    assign bus.spawn_mask  = mask_q;
    assign bus.piece_id    = piece_q;
    assign bus.next_piece  = next_q;
    assign bus.collision   = coll_q;
    assign bus.game_over   = go_q;

endmodule

// File: tb/tb_piece_spawner.sv
// tb/tb_piece_spawner.sv - randomized scoreboard bench for piece_spawner
module tb_piece_spawner;
    import tetris_pkg::*;

    localparam int W1 = 10, H1 = 22, C1 = 4;
    localparam int W2 = 12, H2 = 24, C2 = 1;
    localparam logic [7:0] SEED = 8'hA5;

    typedef logic [H1-1:0][W1-1:0] mask1_t;
    typedef logic [H2-1:0][W2-1:0] mask2_t;

    localparam int DR[7][4] = '{'{0,1,2,3}, '{0,0,1,1}, '{0,1,2,2}, '{0,1,2,2},
                                '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}};
    localparam int DC[7][4] = '{'{0,0,0,0}, '{0,1,0,1}, '{0,0,0,1}, '{1,1,1,0},
                                '{2,1,1,0}, '{0,1,1,2}, '{0,-1,0,1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piece_spawner_if #(.GRID_W(W1), .GRID_H(H1)) bus1 ();
    piece_spawner_if #(.GRID_W(W2), .GRID_H(H2)) bus2 ();

    piece_spawner #(.GRID_W(W1), .GRID_H(H1), .SPAWN_COL(C1), .LFSR_SEED(SEED)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    piece_spawner #(.GRID_W(W2), .GRID_H(H2), .SPAWN_COL(C2), .LFSR_SEED(SEED)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    typedef struct { int edge_n; int piece; mask1_t mask; bit coll; bit go; } spawn_exp_t;
    typedef struct { int edge_n; int piece; } ready_exp_t;

    spawn_exp_t sq[$];
    ready_exp_t rq[$];
    int         ids[$];
    spawn_exp_t mx;
    ready_exp_t mr;

    int  tests = 0;
    int  fails = 0;
    int  ecount;
    bit  prev_ready;
    bit  m_used[7];
    int  m_next;
    bit  m_go;
    int  m_ready_edge;
    int  acc_edge;

    function automatic void chk(bit ok, string name, string got, string want);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endfunction

    function automatic logic [7:0] lfsr_at(int n);
        logic [7:0] v = SEED;
        repeat (n) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic mask1_t mk1(int p);
        mask1_t m = '0;
        for (int k = 0; k < 4; k++) m = m | (mask1_t'(1) << (DR[p][k] * W1 + C1 + DC[p][k]));
        return m;
    endfunction

    function automatic mask2_t mk2(int p);
        mask2_t m = '0;
        for (int k = 0; k < 4; k++) m = m | (mask2_t'(1) << (DR[p][k] * W2 + C2 + DC[p][k]));
        return m;
    endfunction

    // Bag draw whose first attempt lands on clock edge e (edge 1 is the first after reset release).
    task automatic model_draw(input int e);
        int pick = -1;
        int done_j = 7;
        int c;
        int n_used = 0;
        logic [7:0] v;
        for (int j = 0; j < 7 && pick < 0; j++) begin
            v = lfsr_at(e + j - 1);
            c = int'(v[2:0]);
            if (c != 7 && !m_used[c]) begin
                pick = c;
                done_j = j;
            end
        end
        if (pick < 0)
            for (int i = 6; i >= 0; i--) if (!m_used[i]) pick = i;
        m_used[pick] = 1'b1;
        for (int i = 0; i < 7; i++) n_used += int'(m_used[i]);
        if (n_used == 7) for (int i = 0; i < 7; i++) m_used[i] = 1'b0;
        m_next = pick;
        m_ready_edge = e + done_j;
        rq.push_back('{e + done_j, pick});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_used[i] = 1'b0;
        m_next = 0;
        m_go = 1'b0;
        sq.delete();
        rq.delete();
        ids.delete();
        model_draw(1);
    endtask

    task automatic accept(input int a, input mask1_t board);
        spawn_exp_t x;
        x.edge_n = a;
        x.piece  = m_next;
        x.mask   = mk1(m_next);
        x.coll   = |(x.mask & board);
        m_go     = m_go | x.coll;
        x.go     = m_go;
        sq.push_back(x);
        acc_edge = a;
        model_draw(a + 2);
    endtask

    // mode 0: random requests on a board with clutter below row 3; 1: request held high; 2: blocking board
    task automatic cycles(input int n, input int mode);
        mask1_t board;
        bit req;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            req = (mode != 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            board = '0;
            if (mode == 0)
                board = mask1_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom})
                      & mask1_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom})
                      & {{((H1 - 4) * W1){1'b1}}, {(4 * W1){1'b0}}};
            if (mode == 2)
                board = mask1_t'(10'h078) | (mask1_t'(10'h078) << W1);
            bus1.spawn_req = req;
            bus1.board_in  = board;
            if (req && !m_go && ecount >= m_ready_edge) accept(ecount + 1, board);
        end
    endtask

    task automatic check_zero(input string tag);
        chk(bus1.ready == 1'b0, {tag, "_ready"}, $sformatf("%0b", bus1.ready), "0");
        chk(bus1.spawn_valid == 1'b0, {tag, "_valid"}, $sformatf("%0b", bus1.spawn_valid), "0");
        chk(bus1.spawn_mask == '0, {tag, "_mask"}, $sformatf("%h", bus1.spawn_mask), "0");
        chk(bus1.piece_id == 3'd0, {tag, "_piece_id"}, $sformatf("%0d", bus1.piece_id), "0");
        chk(bus1.next_piece == 3'd0, {tag, "_next"}, $sformatf("%0d", bus1.next_piece), "0");
        chk(bus1.game_over == 1'b0, {tag, "_game_over"}, $sformatf("%0b", bus1.game_over), "0");
        chk(bus1.collision == 1'b0, {tag, "_collision"}, $sformatf("%0b", bus1.collision), "0");
    endtask

    task automatic check_perm(input int base, input string tag);
        bit [7:0] seen = '0;
        for (int i = base; i < base + 7; i++) seen[ids[i][2:0]] = 1'b1;
        chk(seen == 8'h7F, tag, $sformatf("%h", seen), "7f");
    endtask

    always @(posedge clk or posedge rst)
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b0;
        end else begin
            if (bus1.spawn_valid) begin
                if (sq.size() == 0) begin
                    chk(1'b0, "unexpected_spawn", $sformatf("piece %0d at edge %0d", bus1.piece_id, ecount), "no spawn");
                end else begin
                    mx = sq.pop_front();
                    chk(ecount == mx.edge_n, "spawn_edge", $sformatf("%0d", ecount), $sformatf("%0d", mx.edge_n));
                    chk(int'(bus1.piece_id) == mx.piece, "piece_id", $sformatf("%0d", bus1.piece_id), $sformatf("%0d", mx.piece));
                    chk(bus1.spawn_mask == mx.mask, "spawn_mask", $sformatf("%h", bus1.spawn_mask), $sformatf("%h", mx.mask));
                    chk($countones(bus1.spawn_mask) == 4, "mask_cells", $sformatf("%0d", $countones(bus1.spawn_mask)), "4");
                    chk(bus1.collision == mx.coll, "collision", $sformatf("%0b", bus1.collision), $sformatf("%0b", mx.coll));
                    chk(bus1.game_over == mx.go, "game_over", $sformatf("%0b", bus1.game_over), $sformatf("%0b", mx.go));
                    ids.push_back(int'(bus1.piece_id));
                end
            end else if (sq.size() != 0 && ecount >= sq[0].edge_n) begin
                mx = sq.pop_front();
                chk(1'b0, "spawn_missing", $sformatf("none by edge %0d", ecount), $sformatf("edge %0d", mx.edge_n));
            end
            if (bus1.ready && !prev_ready) begin
                if (rq.size() == 0) begin
                    chk(1'b0, "unexpected_ready", $sformatf("edge %0d", ecount), "no ready rise");
                end else begin
                    mr = rq.pop_front();
                    chk(ecount == mr.edge_n, "ready_edge", $sformatf("%0d", ecount), $sformatf("%0d", mr.edge_n));
                    chk(int'(bus1.next_piece) == mr.piece, "next_piece", $sformatf("%0d", bus1.next_piece), $sformatf("%0d", mr.piece));
                end
            end else if (!bus1.ready && rq.size() != 0 && ecount > rq[0].edge_n) begin
                mr = rq.pop_front();
                chk(1'b0, "ready_missing", $sformatf("low at edge %0d", ecount), $sformatf("high at %0d", mr.edge_n));
            end
            prev_ready = bus1.ready;
        end
    end

    initial begin
        bit found_s;
        int t;
        bus1.spawn_req = 1'b0;
        bus1.board_in  = '0;
        bus2.spawn_req = 1'b0;
        bus2.board_in  = '0;
        acc_edge = 0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        chk(bus2.ready == 1'b0 && bus2.spawn_mask == '0, "reset_inst2", $sformatf("%0b/%h", bus2.ready, bus2.spawn_mask), "0/0");
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 3000 && ids.size() < 14; i++) cycles(1, 0);
        chk(ids.size() >= 14, "fourteen_spawns", $sformatf("%0d", ids.size()), ">=14");
        if (ids.size() >= 14) begin
            check_perm(0, "bag_perm_0");
            check_perm(7, "bag_perm_1");
        end

        cycles(150, 1);

        acc_edge = -1;
        for (int i = 0; i < 100 && acc_edge < 0; i++) cycles(1, 1);
        @(negedge clk);
        #1 bus1.spawn_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("mid_draw_reset");
        repeat (3) @(negedge clk);
        model_reset();
        #2 rst = 1'b0;

        for (int i = 0; i < 3000 && ids.size() < 7; i++) cycles(1, 0);
        chk(ids.size() >= 7, "post_reset_spawns", $sformatf("%0d", ids.size()), ">=7");
        if (ids.size() >= 7) check_perm(0, "bag_perm_after_reset");
        cycles(40, 0);

        for (int i = 0; i < 200 && !m_go; i++) cycles(1, 2);
        chk(m_go, "collision_spawn_issued", $sformatf("%0b", m_go), "1");
        cycles(60, 1);
        chk(bus1.game_over == 1'b1, "game_over_sticky", $sformatf("%0b", bus1.game_over), "1");
        chk(bus1.ready == 1'b1, "idle_after_game_over", $sformatf("%0b", bus1.ready), "1");
        bus1.spawn_req = 1'b0;
        cycles(5, 0);
        chk(sq.size() == 0 && rq.size() == 0, "queues_drained", $sformatf("%0d/%0d", sq.size(), rq.size()), "0/0");

        found_s = 1'b0;
        for (int k = 0; k < 10 && !found_s; k++) begin
            t = 0;
            while (!bus2.ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk(bus2.ready == 1'b1, "inst2_ready", $sformatf("%0b", bus2.ready), "1");
            #1 bus2.spawn_req = 1'b1;
            @(negedge clk);
            #1 bus2.spawn_req = 1'b0;
            chk(bus2.spawn_valid == 1'b1, "inst2_valid", $sformatf("%0b", bus2.spawn_valid), "1");
            chk(bus2.spawn_mask == mk2(int'(bus2.piece_id)), "inst2_mask",
                $sformatf("%h", bus2.spawn_mask), $sformatf("%h", mk2(int'(bus2.piece_id))));
            if (bus2.piece_id == 3'(S)) begin
                found_s = 1'b1;
                chk(bus2.spawn_mask == ((mask2_t'(12'h00C)) | (mask2_t'(12'h006) << W2)), "inst2_s_cells",
                    $sformatf("%h", bus2.spawn_mask), "(0,3)(0,2)(1,2)(1,1)");
            end
        end
        chk(found_s, "inst2_s_seen", $sformatf("%0b", found_s), "1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piece_spawner.md
Name: piece_spawner

Overview:
Sequential successor to the fixed-position tetromino generator. It owns piece selection through a 7-bag randomiser driven by an LFSR, keeps a one-piece preview, and builds the spawn mask for a board of parametrised size at a parametrised spawn column. It checks the new piece against the current board and flags game over. It sits between the game-control FSM, which requests spawns, and the board/display logic, which consumes the mask.

Parameters:
GRID_W, 10, board width in columns
GRID_H, 22, board height in rows; row 0 is the top
SPAWN_COL, 4, anchor column c for all shapes; legal range 1..GRID_W-3
LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR; must be non-zero

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
spawn_req  in  1  request a new piece; sampled only when ready=1
board_in  in  [GRID_H-1:0][GRID_W-1:0]  occupied cells of the settled board
ready  out  1  high in IDLE; a spawn can be accepted
spawn_valid  out  1  one-cycle pulse; spawn_mask, piece_id and collision are valid
spawn_mask  out  [GRID_H-1:0][GRID_W-1:0]  cells of the spawned piece, indexed [row][col]
piece_id  out  3  type of the spawned piece (block_t)
next_piece  out  3  preview of the next piece
game_over  out  1  sticky; set on spawn collision

Behaviour:
- Reset values: all outputs 0, LFSR=LFSR_SEED, bag_used=7'b0, state=INIT_DRAW.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clock in every state, so there are no stall-dependent patterns.
- Draw procedure (states INIT_DRAW and DRAW), one cycle per attempt:
  - Candidate is lfsr[2:0]. It is accepted if it is not 7 and its bag_used bit is 0.
  - Otherwise a 3-bit retry counter increments. If the counter reaches 7, the lowest-index unused piece is taken. A draw therefore lasts 1..8 cycles.
  - On accept, next_piece <= pick and bag_used[pick] <= 1. If that sets all 7 bits, bag_used <= 0 in the same cycle.
- FSM:
  - INIT_DRAW: fills the preview, then goes to IDLE.
  - IDLE: ready=1. On spawn_req=1 and game_over=0, go to EMIT. spawn_req is ignored while game_over=1.
  - EMIT: exactly one cycle, ready=0.
    - Registered outputs appear in this cycle: piece_id <= next_piece; spawn_mask <= shape(next_piece, SPAWN_COL); spawn_valid=1.
    - collision = |(shape & board_in), evaluated on board_in sampled in the IDLE accept cycle. If collision=1, game_over <= 1.
    - Next state is DRAW.
  - DRAW: refills the preview, then IDLE.
- Latency: request accepted at cycle t; spawn_valid at t+1; ready returns at t+3..t+10.
- spawn_mask holds its value until the next EMIT. spawn_valid is a pulse.
- spawn_req while ready=0 is dropped. There is no queueing; the requester must wait for ready.
- Shapes, as (row, col) cells, with c=SPAWN_COL:
  - LINE(0): (0,c) (1,c) (2,c) (3,c)
  - SMASHBOY(1): (0,c) (0,c+1) (1,c) (1,c+1)
  - L(2): (0,c) (1,c) (2,c) (2,c+1)
  - REVERSE_L(3): (0,c+1) (1,c+1) (2,c+1) (2,c)
  - S(4): (0,c+2) (0,c+1) (1,c+1) (1,c)
  - Z(5): (0,c) (0,c+1) (1,c+1) (1,c+2)
  - T(6): (0,c) (1,c-1) (1,c) (1,c+1)
  - Id 7 is never produced.
- game_over is cleared only by rst.
- rst asserted mid-DRAW or mid-EMIT: immediate return to reset values, and the partial bag is discarded.

Decomposition:
- Package tetris_pkg:
  - block_t enum: LINE=0 .. T=6
  - NUM_PIECES=7
  - LFSR tap constant
  - shape_mask function taking (block_t, anchor column), parametrised by grid size
- Sub-module tetromino_bag contains the LFSR, bag_used, retry counter and the accept/fallback logic. It exposes draw_start, draw_done and pick.

Test Plan:
- Reset, then release: ready rises after 1..8 cycles; next_piece is in 0..6; all other outputs are 0.
- Issue 14 spawns on an empty board: each consecutive group of 7 piece_ids is a permutation of 0..6; each piece_id equals the next_piece shown before its request; no id 7 appears.
- Empty board, spawn with GRID_W=10 and SPAWN_COL=4: spawn_mask has exactly 4 bits set and matches the table for piece_id (e.g. T sets [0][4], [1][3], [1][4], [1][5]); collision=0.
- board_in rows 0-1, cols 3-6 set: spawn gives collision=1 and game_over=1 at t+1; later spawn_req is ignored, with spawn_valid never pulsing again.
- spawn_req held high continuously: exactly one spawn_valid per IDLE visit, and none while ready=0.
- rst pulsed during DRAW: outputs return to 0 asynchronously; after release the sequence matches a fresh-reset run cycle for cycle (same LFSR seed).
- Instance with GRID_W=12, GRID_H=24, SPAWN_COL=1: the S piece occupies (0,3) (0,2) (1,2) (1,1), and the mask has no bits outside the board.
